div4bit_seq_ctrl: RTL

DIV4BIT_SEQ_CTRL -- requirements
Module: div4bit_seq_ctrl

---
 rtl/div4bit_seq_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/div4bit_seq_ctrl.sv
// 4-bit unsigned sequential divider.
// Restoring shift-subtract division, one quotient bit per clock, MSB first.
// A divide-by-zero request skips the iteration phase and reports Error.
//
// Handshake: start is sampled on each rising edge. It is accepted only in
// IDLE; in CALC and DONE it is ignored and nothing is queued. busy is high
// exactly while iterating. done is a one-cycle pulse on which Quotient,
// Remainder, Error and Fractional are valid. Those result registers then
// hold until the next result is written.
module div4bit_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       busy,
  output logic       done,
  output logic [3:0] Quotient,
  output logic [3:0] Remainder,
  output logic       Error,
  output logic       Fractional,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;

  // dividend shifts left each iteration.
  // Quotient bits enter at its LSB, so after four steps it holds the quotient.
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [4:0] partial;
  logic [1:0] cnt;

  logic [4:0] trial_p;
  logic [4:0] next_p;
  logic       q_bit;

  assign dbg_state = state;

  // One restoring-division step: shift in the next dividend bit, then subtract if it fits.
  always_comb begin
    trial_p = {partial[3:0], dividend[3]};
    next_p  = trial_p;
    q_bit   = 1'b0;
    if (trial_p >= {1'b0, divisor}) begin
      next_p = trial_p - {1'b0, divisor};
      q_bit  = 1'b1;
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      Quotient   <= 4'd0;
      Remainder  <= 4'd0;
      Error      <= 1'b0;
      Fractional <= 1'b0;
      dividend   <= 4'd0;
      divisor    <= 4'd0;
      partial    <= 5'd0;
      cnt        <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (B != 4'd0) begin
              dividend <= A;
              divisor  <= B;
              partial  <= 5'd0;
              cnt      <= 2'd3;
              busy     <= 1'b1;
              state    <= CALC;
            end else begin
              Error      <= 1'b1;
              Quotient   <= 4'd0;
              Remainder  <= 4'd0;
              Fractional <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end
          end
        end
        CALC: begin
          partial  <= next_p;
          dividend <= {dividend[2:0], q_bit};
          cnt      <= cnt - 2'd1;
          if (cnt == 2'd0) begin
            Quotient   <= {dividend[2:0], q_bit};
            Remainder  <= next_p[3:0];
            Error      <= 1'b0;
            Fractional <= (next_p[3:0] != 4'd0);
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
